// File: rtl/imem_loader.sv
// imem_loader: streams a length-prefixed program image into instruction memory.
//
// Image format: a 4-byte little-endian byte count, then that many bytes of
// program text. Every 4 data bytes are assembled little-endian into one word.
// Each word is written to BASE_ADDR + 4*index.
//
// Ports
//   clk, rst       : clock, synchronous active-high reset
//   start_i        : one-cycle pulse that begins a load (from IDLE, DONE or ERR)
//   byte_i         : incoming byte; moves on byte_valid_i & byte_ready_o
//   byte_valid_i   : upstream byte valid
//   byte_ready_o   : loader can take a byte (LEN and DATA only)
//   wr_en_o        : one-cycle instruction-memory word write strobe
//   wr_addr_o      : word-aligned absolute byte address of the write
//   wr_data_o      : assembled instruction word
//   busy_o         : a load is in progress
//   done_o         : last load completed; CPU released
//   error_o        : last load rejected on a bad length
//   cpu_rst_o      : holds the CPU in reset until a load completes
//   words_o        : number of words written by the current load
module imem_loader #(
    parameter logic [31:0] BASE_ADDR = 32'hBFC00000,
    parameter int          MEM_SIZE  = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic [7:0]  byte_i,
    input  logic        byte_valid_i,
    output logic        byte_ready_o,
    output logic        wr_en_o,
    output logic [31:0] wr_addr_o,
    output logic [31:0] wr_data_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        error_o,
    output logic        cpu_rst_o,
    output logic [10:0] words_o
);

    typedef enum logic [2:0] {IDLE, LEN, CHECK, DATA, WRITE, DONE, ERR} state_t;

    state_t      state;
    logic [1:0]  byte_cnt;
    logic [31:0] len;

    logic        hs;
    logic [10:0] words_nxt;
    logic        last_word;
    logic        len_bad;

    assign hs        = byte_valid_i && byte_ready_o;
    assign words_nxt = words_o + 11'd1;
    // The word written in WRITE is the last one when its end offset hits len.
    assign last_word = ({19'd0, words_nxt, 2'b00} == len);
    assign len_bad   = (len == 32'd0) || (len[1:0] != 2'b00) || (len > 32'(MEM_SIZE));

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            byte_cnt     <= 2'd0;
            len          <= 32'd0;
            byte_ready_o <= 1'b0;
            wr_en_o      <= 1'b0;
            wr_addr_o    <= BASE_ADDR;
            wr_data_o    <= 32'd0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
            error_o      <= 1'b0;
            cpu_rst_o    <= 1'b1;
            words_o      <= 11'd0;
        end else begin
            case (state)
                IDLE, DONE, ERR: begin
                    if (start_i) begin
                        state        <= LEN;
                        byte_cnt     <= 2'd0;
                        byte_ready_o <= 1'b1;
                        busy_o       <= 1'b1;
                        done_o       <= 1'b0;
                        error_o      <= 1'b0;
                        cpu_rst_o    <= 1'b1;
                        words_o      <= 11'd0;
                    end
                end
                LEN: begin
                    if (hs) begin
                        // Shift in from the top so the first byte ends in [7:0].
                        len      <= {byte_i, len[31:8]};
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            state        <= CHECK;
                            byte_ready_o <= 1'b0;
                        end
                    end
                end
                CHECK: begin
                    byte_cnt <= 2'd0;
                    if (len_bad) begin
                        state   <= ERR;
                        busy_o  <= 1'b0;
                        error_o <= 1'b1;
                    end else begin
                        state        <= DATA;
                        byte_ready_o <= 1'b1;
                    end
                end
                DATA: begin
                    if (hs) begin
                        wr_data_o <= {byte_i, wr_data_o[31:8]};
                        byte_cnt  <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            state        <= WRITE;
                            byte_ready_o <= 1'b0;
                            wr_en_o      <= 1'b1;
                            wr_addr_o    <= BASE_ADDR + {19'd0, words_o, 2'b00};
                        end
                    end
                end
                WRITE: begin
                    wr_en_o <= 1'b0;
                    words_o <= words_nxt;
                    if (last_word) begin
                        state     <= DONE;
                        busy_o    <= 1'b0;
                        done_o    <= 1'b1;
                        cpu_rst_o <= 1'b0;
                    end else begin
                        state        <= DATA;
                        byte_ready_o <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'hBFC00000, meaning the byte address of the first instruction word written.
REQ-002 SHALL have parameter MEM_SIZE, default 4096, meaning the instruction memory capacity in bytes.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start_i  input  1  a one-cycle pulse that begins a load.
REQ-006 SHALL have port byte_i  input  8  the incoming program byte.
REQ-007 SHALL have port byte_valid_i  input  1  asserted when byte_i holds a valid byte.
REQ-008 SHALL have port byte_ready_o  output  1  asserted when the loader accepts a byte.
REQ-009 SHALL have port wr_en_o  output  1  the instruction-memory word write strobe.
REQ-010 SHALL have port wr_addr_o  output  32  the absolute byte address of the write, always word-aligned.
REQ-011 SHALL have port wr_data_o  output  32  the little-endian assembled instruction word.
REQ-012 SHALL have port busy_o  output  1  high while a load is in progress.
REQ-013 SHALL have port done_o  output  1  high once a load has completed successfully.
REQ-014 SHALL have port error_o  output  1  high once a load has been rejected.
REQ-015 SHALL have port cpu_rst_o  output  1  holds the CPU in reset until a load completes.
REQ-016 SHALL have port words_o  output  11  the count of words written in the current load.

Function
REQ-017 SHALL transfer a byte only on a cycle where byte_valid_i and byte_ready_o are both 1.
REQ-018 SHALL implement the states IDLE, LEN, CHECK, DATA, WRITE, DONE and ERR.
REQ-019 SHALL go from IDLE to LEN on start_i, and SHALL ignore start_i in LEN, CHECK, DATA and WRITE.
REQ-020 SHALL, in LEN, collect 4 bytes as a little-endian 32-bit byte count, with the first byte as bits [7:0], then enter CHECK.
REQ-021 SHALL, in CHECK, spend one cycle with byte_ready_o=0 and enter ERR if the length is 0, is not a multiple of 4, or exceeds MEM_SIZE; otherwise it SHALL enter DATA.
REQ-022 SHALL, in DATA, collect 4 bytes into wr_data_o so that the first byte is [7:0] and the fourth is [31:24], then enter WRITE.
REQ-023 SHALL, in WRITE, hold wr_en_o=1 for exactly one cycle with byte_ready_o=0, wr_addr_o = BASE_ADDR + 4*words_o, and words_o incrementing after the write.
REQ-024 SHALL, after WRITE, enter DONE if 4*(words_o+1) equals the length, else return to DATA.
REQ-025 SHALL assert byte_ready_o only in LEN and DATA.
REQ-026 SHALL keep wr_en_o=0 in every state other than WRITE.
REQ-027 SHALL, in DONE, set done_o=1, cpu_rst_o=0 and busy_o=0.
REQ-028 SHALL, in ERR, set error_o=1, cpu_rst_o=1 and busy_o=0.
REQ-029 SHALL, on start_i in DONE or ERR, clear done_o, error_o and words_o, set cpu_rst_o=1 and enter LEN.
REQ-030 SHALL set busy_o=1 exactly in LEN, CHECK, DATA and WRITE.
REQ-031 SHALL tolerate byte_valid_i gaps of any length without losing or duplicating bytes.
REQ-032 SHALL ignore byte_valid_i in IDLE, DONE and ERR.
REQ-033 SHALL produce the first write exactly 1 cycle after the 4th data byte is accepted.

Reset
REQ-034 SHALL, when rst=1, force state=IDLE, byte_ready_o=0, wr_en_o=0, wr_addr_o=BASE_ADDR, wr_data_o=0, busy_o=0, done_o=0, error_o=0, cpu_rst_o=1 and words_o=0.
REQ-035 SHALL let rst take priority over start_i and over a byte handshake on the same cycle.
REQ-036 SHALL, on rst mid-load, discard any partial word and issue no further writes.

Verification
REQ-037 SHALL cover: start_i, then bytes 08 00 00 00, 13 05 10 00, 6F 00 00 00 -> writes (BFC00000, 00100513) and (BFC00004, 0000006F), then done_o=1, cpu_rst_o=0 and words_o=2.
REQ-038 SHALL cover: length bytes 06 00 00 00 -> error_o=1, no write occurs, and cpu_rst_o stays 1.
REQ-039 SHALL cover: length 00 10 00 00 (4096) with 1024 words -> last write at BFC00FFC and words_o=1024; length 04 10 00 00 -> ERR.
REQ-040 SHALL cover: byte_valid_i toggled randomly, including multi-cycle gaps -> wr_data_o sequence is identical to the gap-free run.
REQ-041 SHALL cover: rst asserted after 2 data bytes, then a new load -> no stray write occurs, and the first new write is at BFC00000 with correct data.
REQ-042 SHALL cover: start_i pulsed during DATA -> it is ignored; then start_i in DONE -> a reload occurs with cpu_rst_o reasserted.
